instruction_fetch_unit: RTL and testbench

- Producer side of the instruction buffer's write port. Keeps the fetch PC, issues one instruction-memory read at a time, and pushes each returned word into the buffer through write_en/data_in.
- Honours the buffer's is_full flag, so no word is ever dropped.
- A redirect from execute (branch or jump) reloads the PC and squashes any fetch already in flight.

---
 rtl/cpu_fetch_pkg.sv | 14 +
 rtl/instruction_fetch_unit_if.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        WRITE,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of redirect, instruction-memory and instruction-buffer signals seen by the fetch unit.
interface instruction_fetch_unit_if #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;
    logic                  buf_is_full;
    logic                  buf_write_en;
    logic [INST_WIDTH-1:0] buf_data_in;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  buf_is_full,
        output imem_req_valid, imem_req_addr,
        output buf_write_en, buf_data_in, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output buf_is_full,
        input  imem_req_valid, imem_req_addr,
        input  buf_write_en, buf_data_in, fetch_pc
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, single-outstanding instruction-memory reader and producer for the instruction buffer.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned           PC_STEP    = DEFAULT_PC_STEP
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [INST_WIDTH-1:0] hold;
    logic                  req_valid;
    logic                  req_accept;
    logic                  write_en;
    logic                  capture;

    assign redirect_target = bus.redirect_pc & ~ADDR_WIDTH'(3);

    // Request is suppressed while reset is held, even though the state already reads FETCH.
    assign req_valid  = (state == FETCH) && reset;
    assign req_accept = req_valid && bus.imem_req_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_next = state;
        pc_next    = pc;
        write_en   = 1'b0;
        capture    = 1'b0;

        case (state)
            FETCH: begin
                if (bus.redirect_valid) begin
                    state_next = req_accept ? DRAIN : FETCH;
                end else if (req_accept) begin
                    state_next = WAIT;
                    pc_next    = pc + ADDR_WIDTH'(PC_STEP);
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    state_next = bus.imem_resp_valid ? FETCH : DRAIN;
                end else if (bus.imem_resp_valid) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (bus.redirect_valid) begin
                    state_next = FETCH;
                end else begin
                    write_en = ~bus.buf_is_full;
                    if (!bus.buf_is_full) begin
                        state_next = FETCH;
                    end
                end
            end
            DRAIN: begin
                // The squashed response is consumed even when a second redirect lands with it;
                // waiting for another response here would never end.
                if (bus.imem_resp_valid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        if (bus.redirect_valid) begin
            pc_next = redirect_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // NOTE: the hold register is a single word, so clearing it on reset is cheap and keeps outputs X-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (capture) begin
            hold <= bus.imem_resp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.buf_write_en   = write_en;
    assign bus.buf_data_in    = hold;
    assign bus.fetch_pc       = pc;

    // A response is only legal while a request is outstanding or being drained.
    resp_in_expected_state: assert property (
        @(posedge clk) disable iff (!reset)
        bus.imem_resp_valid |-> (state == WAIT || state == DRAIN)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for the fetch unit with a latency-configurable memory model.
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;

    instruction_fetch_unit_if #(.INST_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

    instruction_fetch_unit #(
        .INST_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int cyc      = 0;
    int last_wr_cyc = -1;
    bit spacing_chk = 1'b0;
    int mem_lat  = 1;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_wr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_wr(input logic [31:0] d);
        exp_wr.push_back(d);
    endtask

    // One clean fetch from FETCH (ready low) back to FETCH, memory latency 1, buffer not full.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        push_req(a);
        push_wr(d);
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        step();
        step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or a buffer write.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                if (exp_addr.size() == 0) unexpected("unexpected_req", bus_if.imem_req_addr);
                else check("req_addr", bus_if.imem_req_addr, exp_addr.pop_front());
            end
            if (bus_if.buf_write_en) begin
                if (exp_wr.size() == 0) unexpected("unexpected_write", bus_if.buf_data_in);
                else check("write_data", bus_if.buf_data_in, exp_wr.pop_front());
                if (spacing_chk && last_wr_cyc >= 0)
                    check("write_spacing", 32'(cyc - last_wr_cyc), 32'd3);
                last_wr_cyc = cyc;
                wr_count++;
            end
            cyc++;
        end
    end

    // Memory model: word at address a is 0xA5A5_0000 + a/4, returned mem_lat cycles after acceptance.
    initial begin
        bit          hs;
        logic [31:0] a_s;
        logic [31:0] paddr;
        int          cnt;
        cnt   = 0;
        paddr = '0;
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            hs  = bus_if.imem_req_valid && bus_if.imem_req_ready;
            a_s = bus_if.imem_req_addr;
            @(posedge clk);
            #1;
            bus_if.imem_resp_valid = 1'b0;
            if (hs) begin
                cnt   = mem_lat;
                paddr = a_s;
            end
            if (cnt == 1) begin
                bus_if.imem_resp_valid = 1'b1;
                bus_if.imem_resp_data  = 32'hA5A5_0000 + (paddr >> 2);
            end
            if (cnt > 0) cnt--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc0;
        reset                 = 1'b0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.buf_is_full    = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;

        // Reset state, then streaming with 1-cycle memory and a never-full buffer.
        step();
        step();
        check("rst_req_valid", bus_if.imem_req_valid, 0);
        check("rst_write_en", bus_if.buf_write_en, 0);
        check("rst_fetch_pc", bus_if.fetch_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            push_req(32'(i * 4));
            push_wr(32'hA5A5_0000 + 32'(i));
        end
        spacing_chk = 1'b1;
        bus_if.imem_req_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("first_req_valid", bus_if.imem_req_valid, 1);
        check("first_req_addr", bus_if.imem_req_addr, 32'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (wr_count >= 4) break;
        end
        bus_if.imem_req_ready = 1'b0;
        spacing_chk = 1'b0;
        check("stream_writes", 32'(wr_count), 32'd4);

        // Buffer full for 10 cycles while holding a word.
        push_req(32'h10);
        push_wr(32'hA5A5_0004);
        bus_if.buf_is_full    = 1'b1;
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("full_no_write", bus_if.buf_write_en, 0);
            check("full_no_req", bus_if.imem_req_valid, 0);
            check("full_data_stable", bus_if.buf_data_in, 32'hA5A5_0004);
            step();
        end
        wc0 = wr_count;
        push_req(32'h14);
        push_wr(32'hA5A5_0005);
        bus_if.buf_is_full    = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        step();
        check("release_one_write", 32'(wr_count), 32'(wc0 + 1));
        check("release_req_valid", bus_if.imem_req_valid, 1);
        check("release_req_addr", bus_if.imem_req_addr, 32'h14);
        step();
        bus_if.imem_req_ready = 1'b0;
        step();
        step();
        check("release_next_write", 32'(wr_count), 32'(wc0 + 2));

        // Redirect in WAIT; the squashed response arrives two cycles later.
        mem_lat = 3;
        push_req(32'h18);
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_1003;
        step();
        bus_if.redirect_valid = 1'b0;
        wc0 = wr_count;
        check("wait_redir_pc", bus_if.fetch_pc, 32'h1000);
        check("drain_no_req", bus_if.imem_req_valid, 0);
        step();
        step();
        check("after_drain_req_valid", bus_if.imem_req_valid, 1);
        check("after_drain_req_addr", bus_if.imem_req_addr, 32'h1000);
        check("drain_no_write", 32'(wr_count), 32'(wc0));
        mem_lat = 1;
        fetch_one(32'h1000, 32'hA5A5_0400);

        // Redirect together with a response, then together with a handshake.
        wc0 = wr_count;
        push_req(32'h1004);
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_2000;
        step();
        bus_if.redirect_valid = 1'b0;
        check("resp_redir_req_valid", bus_if.imem_req_valid, 1);
        check("resp_redir_req_addr", bus_if.imem_req_addr, 32'h2000);
        push_req(32'h2000);
        bus_if.imem_req_ready = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_3000;
        step();
        bus_if.imem_req_ready = 1'b0;
        bus_if.redirect_valid = 1'b0;
        check("hs_redir_no_req", bus_if.imem_req_valid, 0);
        check("hs_redir_pc", bus_if.fetch_pc, 32'h3000);
        step();
        check("hs_redir_req_valid", bus_if.imem_req_valid, 1);
        check("hs_redir_req_addr", bus_if.imem_req_addr, 32'h3000);
        check("redir_no_write", 32'(wr_count), 32'(wc0));
        fetch_one(32'h3000, 32'hA5A5_0C00);

        // Redirect of an unaccepted request keeps FETCH with the new, aligned address.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_4002;
        step();
        bus_if.redirect_valid = 1'b0;
        check("abort_req_valid", bus_if.imem_req_valid, 1);
        check("abort_req_addr", bus_if.imem_req_addr, 32'h4000);

        // Reset asserted mid-WAIT; the late response arrives while reset is still low.
        mem_lat = 4;
        wc0 = wr_count;
        push_req(32'h4000);
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("midrst_req_valid", bus_if.imem_req_valid, 0);
        check("midrst_write_en", bus_if.buf_write_en, 0);
        check("midrst_fetch_pc", bus_if.fetch_pc, 32'h0);
        step();
        step();
        check("late_resp_no_write", bus_if.buf_write_en, 0);
        step();
        mem_lat = 1;
        reset = 1'b1;
        #1;
        check("post_rst_req_valid", bus_if.imem_req_valid, 1);
        check("post_rst_req_addr", bus_if.imem_req_addr, 32'h0);
        check("midrst_write_count", 32'(wr_count), 32'(wc0));

        // Request held while memory is not ready.
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid", bus_if.imem_req_valid, 1);
            check("stall_req_addr", bus_if.imem_req_addr, 32'h0);
            check("stall_fetch_pc", bus_if.fetch_pc, 32'h0);
            step();
        end
        push_req(32'h0);
        push_wr(32'hA5A5_0000);
        bus_if.imem_req_ready = 1'b1;
        step();
        bus_if.imem_req_ready = 1'b0;
        check("ready_advances_pc", bus_if.fetch_pc, 32'h4);
        step();
        step();

        repeat (3) step();
        check("req_queue_empty", 32'(exp_addr.size()), 32'd0);
        check("write_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
